// File: rtl/demux4_pkg.sv
// rtl/demux4_pkg.sv - shared lane count, lane index type and lane bit-slice helper for demux4_stream
package demux4_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  // Low bit of lane's field inside a packed bus of NUM_LANES equal-width fields.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/demux4_lane.sv
// rtl/demux4_lane.sv - one-entry register slice holding the word for a single output lane
module demux4_lane #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          stalled
);

  // A load wins over a drain so a full lane with ready high reloads at full rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign stalled = valid && !ready;

endmodule

// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - 1-to-4 valid/ready stream demultiplexer with one-entry lane registers
// Define DEMUX4_CNT_EN to add per-lane accepted-word counters on out_cnt.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int DW = 8
`ifdef DEMUX4_CNT_EN
  , parameter int CW = 8
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic [DW-1:0]         in_data,
  output logic [NUM_LANES-1:0]  out_valid,
  input  logic [NUM_LANES-1:0]  out_ready,
  output logic [NUM_LANES*DW-1:0] out_data
`ifdef DEMUX4_CNT_EN
  , output logic [NUM_LANES*CW-1:0] out_cnt
`endif
);

  logic [NUM_LANES-1:0] load;
  logic [NUM_LANES-1:0] stalled;
  logic                 accept;
  lane_idx_t            sel;

  assign sel = lane_idx_t'(in_sel);

  // Only the addressed lane can block the input; other lanes never stall it.
  assign in_ready = !reset && !stalled[sel];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int LO = lane_lo(i, DW);

    assign load[i] = accept && (sel == lane_idx_t'(i));

    demux4_lane #(
      .DW(DW)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (in_data),
      .ready     (out_ready[i]),
      .valid     (out_valid[i]),
      .data      (out_data[LO +: DW]),
      .stalled   (stalled[i])
    );

`ifdef DEMUX4_CNT_EN
    localparam int CLO = lane_lo(i, CW);
    logic [CW-1:0] cnt;

    // Free-running modulo-2^CW count of words accepted into this lane.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (load[i]) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign out_cnt[CLO +: CW] = cnt;
`endif
  end

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - randomized and directed self-checking bench for demux4_stream
module tb_demux4_stream;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'h0;
  logic [4*DW-1:0] out_data;
`ifdef DEMUX4_CNT_EN
  logic [4*CW-1:0] out_cnt;
`endif

  demux4_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX4_CNT_EN
    , .out_cnt (out_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each lane is a mailbox holding at most one word.
  bit       full [4];
  logic [7:0] held [4];
  int       acc_cnt [4];
  int       n_acc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      full[i] = 1'b0;
      held[i] = '0;
      acc_cnt[i] = 0;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ev;
    for (int i = 0; i < 4; i++) ev[i] = full[i];
    check("out_valid", out_valid, ev);
    for (int i = 0; i < 4; i++)
      if (full[i]) check($sformatf("out_data[%0d]", i), out_data[i*DW +: DW], held[i]);
`ifdef DEMUX4_CNT_EN
    for (int i = 0; i < 4; i++)
      check($sformatf("out_cnt[%0d]", i), out_cnt[i*CW +: CW], acc_cnt[i] % (1 << CW));
`endif
  endtask

  // One clock: drive at negedge, check outputs and in_ready, then advance the model at posedge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    bit exp_rdy;
    bit acc;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    check_outputs();
    exp_rdy = !full[s] || r[s];
    check("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (full[i] && r[i]) full[i] = 1'b0;
    if (acc) begin
      full[s] = 1'b1;
      held[s] = d;
      acc_cnt[s]++;
      n_acc++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    model_clear();
    #1;
    check("reset out_valid", out_valid, 4'h0);
    check("reset in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Route: one word per lane, every consumer ready.
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i), 8'hA0 + 8'(i), 4'hF);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
    for (int i = 0; i < 4; i++) check($sformatf("route lane%0d", i), out_data[i*DW +: DW], 8'hA0 + 8'(i));
    cycle(1'b0, 2'd0, 8'h00, 4'hF);

    // Stall: lane1 full and blocked, lane3 still accepts.
    cycle(1'b1, 2'd1, 8'h44, 4'h0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 2'd1, 8'h55, 4'h0);
    check("stall lane1 holds old", out_data[1*DW +: DW], 8'h44);
    cycle(1'b1, 2'd3, 8'h77, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
    check("stall lane3 valid", out_valid[3], 1'b1);
    check("stall lane3 data", out_data[3*DW +: DW], 8'h77);
    cycle(1'b1, 2'd1, 8'h55, 4'hF);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);

    // Simultaneous drain and reload of lane2.
    cycle(1'b1, 2'd2, 8'h11, 4'h0);
    cycle(1'b1, 2'd2, 8'h22, 4'h4);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
    check("simul lane2 valid", out_valid[2], 1'b1);
    check("simul lane2 data", out_data[2*DW +: DW], 8'h22);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);

    // Back-to-back into lane0.
    base = n_acc;
    for (int k = 0; k < 16; k++) cycle(1'b1, 2'd0, 8'(8'hB0 + k), 4'h1);
    check("b2b accepts", n_acc - base, 16);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
    check("b2b last word", out_data[0*DW +: DW], 8'hBF);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);

    // Reset mid-stream with lanes 0 and 2 full.
    cycle(1'b1, 2'd0, 8'hC0, 4'h0);
    cycle(1'b1, 2'd2, 8'hC2, 4'h0);
    @(negedge clk);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hE1; out_ready = 4'h0;
    #1 check("pre-reset out_valid", out_valid, 4'h5);
    #1 reset = 1'b1;
    #1 check("reset async out_valid", out_valid, 4'h0);
    check("reset async out_data", out_data, '0);
    check("reset in_ready", in_ready, 1'b0);
    model_clear();
    @(posedge clk);
    #1 check("reset no load", out_valid, 4'h0);
    @(posedge clk);
    #2 reset = 1'b0;
    cycle(1'b1, 2'd1, 8'hE1, 4'h0);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);
    check("post-reset accept", out_valid, 4'h2);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);

`ifdef DEMUX4_CNT_EN
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    for (int k = 0; k < 257; k++) cycle(1'b1, 2'd3, 8'(k), 4'h8);
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
    check("cnt lane3 wrap", out_cnt[3*CW +: CW], 8'd1);
    check("cnt others", out_cnt[0 +: 3*CW], '0);
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));
    cycle(1'b0, 2'd0, 8'h00, 4'hF);
    cycle(1'b0, 2'd0, 8'h00, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
